icache_refill_beat_assembler: RTL and testbench



---
 rtl/icache_refill_beat_assembler.sv | 183 ++++++++++++++++++
 tb/tb_icache_refill_beat_assembler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_beat_assembler.sv
// -----------------------------------------------------------------------------
// icache_refill_beat_assembler
//
// Purpose: collects narrow memory refill beats, in any arrival order, into full
// ICache fetch lines and hands each completed line plus its transaction tag to
// the ICache memory adapter's ack side. A single output register lets the next
// line assemble while the previous one waits for the adapter. Protocol problems
// (tag change inside a line, duplicate beats, misplaced beat_last) raise sticky
// error flags.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   beat_vld/beat_rdy beat handshake from the memory model
//   beat_data         one BEAT_WIDTH slice of the line
//   beat_idx          slice position inside the line
//   beat_tag          {opcode, mshr idx, txnid} transaction tag
//   beat_last         memory's end-of-line marker (checked only, not used for framing)
//   line_vld/line_rdy assembled-line handshake to the adapter
//   line_data         assembled line
//   line_tag          tag of the assembled line
//   err_tag_mismatch  sticky: a beat's tag differed from the line's first tag
//   err_beat_count    sticky: duplicate beat or misplaced beat_last
//   busy              assembly in progress or output register occupied
// -----------------------------------------------------------------------------
module icache_refill_beat_assembler #(
    parameter int ICACHE_REQ_OPCODE_WIDTH = 2,
    parameter int MSHR_ENTRY_INDEX_WIDTH  = 2,
    parameter int ROB_ENTRY_ID_WIDTH      = 4,
    parameter int FETCH_DATA_WIDTH        = 256,
    parameter int BEAT_WIDTH              = 64,
    parameter int NUM_BEATS               = FETCH_DATA_WIDTH / BEAT_WIDTH,
    parameter int BEAT_IDX_WIDTH          = $clog2(NUM_BEATS),
    parameter int TAG_WIDTH               = ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH
                                            + ROB_ENTRY_ID_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat_vld,
    output logic                        beat_rdy,
    input  logic [BEAT_WIDTH-1:0]       beat_data,
    input  logic [BEAT_IDX_WIDTH-1:0]   beat_idx,
    input  logic [TAG_WIDTH-1:0]        beat_tag,
    input  logic                        beat_last,
    output logic                        line_vld,
    input  logic                        line_rdy,
    output logic [FETCH_DATA_WIDTH-1:0] line_data,
    output logic [TAG_WIDTH-1:0]        line_tag,
    output logic                        err_tag_mismatch,
    output logic                        err_beat_count,
    output logic                        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_e;

    // Beat count that, once reached before the current beat, makes it the completing one.
    localparam logic [BEAT_IDX_WIDTH:0] LAST_CNT = (BEAT_IDX_WIDTH + 1)'(NUM_BEATS - 1);

    state_e                      state_q, state_d;
    logic [BEAT_IDX_WIDTH:0]     cnt_q, cnt_d;
    logic [NUM_BEATS-1:0]        mask_q, mask_d;
    logic [FETCH_DATA_WIDTH-1:0] asm_data_q, asm_data_d;
    logic [TAG_WIDTH-1:0]        asm_tag_q, asm_tag_d;
    logic [FETCH_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_WIDTH-1:0]        out_tag_q, out_tag_d;
    logic                        out_vld_q, out_vld_d;
    logic                        err_tag_q, err_tag_d;
    logic                        err_cnt_q, err_cnt_d;

    logic beat_fire;
    logic beat_done;
    logic out_free;

    assign beat_rdy  = (state_q != S_FULL);
    assign beat_fire = beat_vld && beat_rdy;
    // IDLE always holds cnt_q == 0, so a single-beat line completes from IDLE too.
    assign beat_done = beat_fire && (cnt_q == LAST_CNT);
    // The output register can take a line if empty or being popped on this edge.
    assign out_free  = !out_vld_q || line_rdy;

    always_comb begin
        // NOTE: every _d signal gets a default before any branch; a path that
        // skipped one would infer a latch instead of combinational logic.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        asm_data_d = asm_data_q;
        asm_tag_d  = asm_tag_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        out_vld_d  = out_vld_q && !line_rdy;
        err_tag_d  = err_tag_q;
        err_cnt_d  = err_cnt_q;

        if (beat_fire) begin
            asm_data_d[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
            cnt_d = cnt_q + 1'b1;

            if (state_q == S_IDLE) begin
                asm_tag_d = beat_tag;
                mask_d    = '0;
            end else begin
                if (beat_tag != asm_tag_q) begin
                    err_tag_d = 1'b1;
                end
                // A repeated position still overwrites and still counts.
                if (mask_q[beat_idx]) begin
                    err_cnt_d = 1'b1;
                end
            end
            mask_d[beat_idx] = 1'b1;

            // beat_last must be set exactly on the beat that completes the line.
            if (beat_last != beat_done) begin
                err_cnt_d = 1'b1;
            end

            if (beat_done) begin
                if (out_free) begin
                    // asm_data_d already includes this beat: forward the merged line.
                    out_data_d = asm_data_d;
                    out_tag_d  = asm_tag_d;
                    out_vld_d  = 1'b1;
                    cnt_d      = '0;
                    mask_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_FULL;
                end
            end else begin
                state_d = S_FILL;
            end
        end else if ((state_q == S_FULL) && out_free) begin
            out_data_d = asm_data_q;
            out_tag_d  = asm_tag_q;
            out_vld_d  = 1'b1;
            cnt_d      = '0;
            mask_d     = '0;
            state_d    = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    // The wide data registers are reset as well: the output must read 0 after
    // reset and the assembly buffer must not leak a discarded line's beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            asm_data_q <= '0;
            asm_tag_q  <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            out_vld_q  <= 1'b0;
            err_tag_q  <= 1'b0;
            err_cnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            asm_data_q <= asm_data_d;
            asm_tag_q  <= asm_tag_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
            out_vld_q  <= out_vld_d;
            err_tag_q  <= err_tag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign line_vld         = out_vld_q;
    assign line_data        = out_data_q;
    assign line_tag         = out_tag_q;
    assign err_tag_mismatch = err_tag_q;
    assign err_beat_count   = err_cnt_q;
    assign busy             = (state_q != S_IDLE) || out_vld_q;

endmodule

// File: tb/tb_icache_refill_beat_assembler.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_beat_assembler
//
// Directed scenarios followed by randomized lines. A scoreboard model treats the
// assembler as "a buffer of NUM_BEATS slots; every NUM_BEATS accepted beats form
// one line carrying the first beat's tag" and predicts lines and error flags.
// -----------------------------------------------------------------------------
module tb_icache_refill_beat_assembler;

    localparam int FW = 256;
    localparam int BW = 64;
    localparam int NB = 4;
    localparam int IW = 2;
    localparam int TW = 8;

    logic          clk;
    logic          rst;
    logic          beat_vld;
    logic          beat_rdy;
    logic [BW-1:0] beat_data;
    logic [IW-1:0] beat_idx;
    logic [TW-1:0] beat_tag;
    logic          beat_last;
    logic          line_vld;
    logic          line_rdy;
    logic [FW-1:0] line_data;
    logic [TW-1:0] line_tag;
    logic          err_tag_mismatch;
    logic          err_beat_count;
    logic          busy;

    icache_refill_beat_assembler dut (
        .clk              (clk),
        .rst              (rst),
        .beat_vld         (beat_vld),
        .beat_rdy         (beat_rdy),
        .beat_data        (beat_data),
        .beat_idx         (beat_idx),
        .beat_tag         (beat_tag),
        .beat_last        (beat_last),
        .line_vld         (line_vld),
        .line_rdy         (line_rdy),
        .line_data        (line_data),
        .line_tag         (line_tag),
        .err_tag_mismatch (err_tag_mismatch),
        .err_beat_count   (err_beat_count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] data;
        logic [TW-1:0] tag;
    } line_t;

    int checks = 0;
    int errors = 0;

    // Scoreboard / reference model state.
    line_t         exp_q[$];
    logic [FW-1:0] m_line;
    logic [NB-1:0] m_seen;
    logic [TW-1:0] m_tag;
    int            m_cnt;
    logic          exp_err_tag;
    logic          exp_err_cnt;

    // Observation state.
    int   edge_cnt     = 0;
    int   pop_cyc[$];
    logic rdy_dropped  = 1'b0;
    logic rand_rdy     = 1'b0;

    localparam logic [BW-1:0] D0 = 64'h1111_1111_1111_1111;
    localparam logic [BW-1:0] D1 = 64'h2222_2222_2222_2222;
    localparam logic [BW-1:0] D2 = 64'h3333_3333_3333_3333;
    localparam logic [BW-1:0] D3 = 64'h4444_4444_4444_4444;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_line      = '0;
        m_seen      = '0;
        m_tag       = '0;
        m_cnt       = 0;
        exp_err_tag = 1'b0;
        exp_err_cnt = 1'b0;
    endtask

    task automatic model_accept(input int idx, input logic [BW-1:0] d, input logic [TW-1:0] tag,
                                input logic last);
        line_t l;
        if (m_cnt == 0) m_tag = tag;
        else begin
            if (tag != m_tag) exp_err_tag = 1'b1;
            if (m_seen[idx]) exp_err_cnt = 1'b1;
        end
        m_line[idx*BW +: BW] = d;
        m_seen[idx] = 1'b1;
        m_cnt++;
        if (last != (m_cnt == NB)) exp_err_cnt = 1'b1;
        if (m_cnt == NB) begin
            l.data = m_line;
            l.tag  = m_tag;
            exp_q.push_back(l);
            m_cnt  = 0;
            m_seen = '0;
        end
    endtask

    // Called at the negative edge: checks pops against the scoreboard and the flags.
    task automatic observe();
        line_t l;
        if (beat_vld && !beat_rdy) rdy_dropped = 1'b1;
        check("err_tag_flag", FW'(err_tag_mismatch), FW'(exp_err_tag));
        check("err_cnt_flag", FW'(err_beat_count), FW'(exp_err_cnt));
        if (line_vld && line_rdy) begin
            pop_cyc.push_back(edge_cnt);
            if (exp_q.size() == 0) begin
                check("spurious_line", FW'(line_vld), FW'(0));
            end else begin
                l = exp_q.pop_front();
                check("pop_data", line_data, l.data);
                check("pop_tag", FW'(line_tag), FW'(l.tag));
            end
        end
    endtask

    // One clock: entered and left at posedge+1.
    task automatic tick();
        if (rand_rdy) line_rdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        observe();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic idle(input int n);
        beat_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_beat(input int idx, input logic [BW-1:0] d, input logic [TW-1:0] tag,
                             input logic last);
        logic acc;
        int   waited;
        acc       = 1'b0;
        waited    = 0;
        beat_vld  = 1'b1;
        beat_idx  = IW'(idx);
        beat_data = d;
        beat_tag  = tag;
        beat_last = last;
        while (!acc && waited < 200) begin
            if (rand_rdy) line_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = beat_rdy;
            observe();
            @(posedge clk);
            edge_cnt++;
            #1;
            waited++;
        end
        if (acc) model_accept(idx, d, tag, last);
        else check("beat_accept_timeout", FW'(acc), FW'(1));
    endtask

    task automatic apply_reset();
        beat_vld = 1'b0;
        rst      = 1'b1;
        model_clear();
        #3;
        check("rst_line_vld", FW'(line_vld), FW'(0));
        check("rst_line_data", line_data, FW'(0));
        check("rst_line_tag", FW'(line_tag), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        check("rst_beat_rdy", FW'(beat_rdy), FW'(1));
        check("rst_errs", FW'({err_tag_mismatch, err_beat_count}), FW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] ref_line;
        int            order[NB];
        logic [BW-1:0] rd[NB];
        logic [TW-1:0] rtag;
        int            base;
        int            budget;

        rst       = 1'b1;
        beat_vld  = 1'b0;
        beat_data = '0;
        beat_idx  = '0;
        beat_tag  = '0;
        beat_last = 1'b0;
        line_rdy  = 1'b1;
        model_clear();
        ref_line  = {D3, D2, D1, D0};
        #2;
        apply_reset();

        // 1: in-order fill.
        send_beat(0, D0, 8'h5A, 1'b0);
        send_beat(1, D1, 8'h5A, 1'b0);
        send_beat(2, D2, 8'h5A, 1'b0);
        check("inorder_not_early", FW'(line_vld), FW'(0));
        send_beat(3, D3, 8'h5A, 1'b1);
        beat_vld = 1'b0;
        check("inorder_vld", FW'(line_vld), FW'(1));
        check("inorder_data", line_data, ref_line);
        check("inorder_tag", FW'(line_tag), FW'(8'h5A));
        idle(1);
        check("inorder_popped", FW'(line_vld), FW'(0));

        // 2: critical-word-first order 2,3,0,1.
        send_beat(2, D2, 8'h3C, 1'b0);
        send_beat(3, D3, 8'h3C, 1'b0);
        send_beat(0, D0, 8'h3C, 1'b0);
        check("cwf_not_early", FW'(line_vld), FW'(0));
        send_beat(1, D1, 8'h3C, 1'b1);
        beat_vld = 1'b0;
        check("cwf_vld", FW'(line_vld), FW'(1));
        check("cwf_data", line_data, ref_line);
        idle(1);

        // 3: back-pressure with two lines A then B.
        line_rdy = 1'b0;
        for (int i = 0; i < NB; i++) send_beat(i, 64'hA000 + 64'(i), 8'hA1, i == NB - 1);
        for (int i = 0; i < NB; i++) send_beat(i, 64'hB000 + 64'(i), 8'hB2, i == NB - 1);
        beat_vld = 1'b0;
        check("bp_full_rdy", FW'(beat_rdy), FW'(0));
        check("bp_busy", FW'(busy), FW'(1));
        idle(3);
        check("bp_hold_vld", FW'(line_vld), FW'(1));
        check("bp_hold_tag", FW'(line_tag), FW'(8'hA1));
        check("bp_hold_data", line_data, {64'hA003, 64'hA002, 64'hA001, 64'hA000});
        line_rdy = 1'b1;
        tick();
        check("bp_b_vld", FW'(line_vld), FW'(1));
        check("bp_b_tag", FW'(line_tag), FW'(8'hB2));
        check("bp_b_rdy", FW'(beat_rdy), FW'(1));
        tick();
        check("bp_drained", FW'(line_vld), FW'(0));
        check("bp_idle", FW'(busy), FW'(0));

        // 4: streaming three lines back-to-back.
        rdy_dropped = 1'b0;
        pop_cyc.delete();
        base = edge_cnt;
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < NB; i++)
                send_beat(i, {32'(l), 32'(i)}, TW'(8'h10 + l), i == NB - 1);
        idle(2);
        check("stream_rdy_never_low", FW'(rdy_dropped), FW'(0));
        check("stream_pops", FW'(pop_cyc.size()), FW'(3));
        for (int l = 0; l < 3 && l < pop_cyc.size(); l++)
            check("stream_pop_cycle", FW'(pop_cyc[l] - base + 1), FW'(5 + 4 * l));

        // 5a: tag change on beat 2.
        send_beat(0, D0, 8'h33, 1'b0);
        send_beat(1, D1, 8'h33, 1'b0);
        send_beat(2, D2, 8'h77, 1'b0);
        beat_vld = 1'b0;
        check("tagerr_flag", FW'(err_tag_mismatch), FW'(1));
        check("tagerr_no_cnt", FW'(err_beat_count), FW'(0));
        send_beat(3, D3, 8'h33, 1'b1);
        beat_vld = 1'b0;
        check("tagerr_keeps_tag", FW'(line_tag), FW'(8'h33));
        idle(2);
        check("tagerr_sticky", FW'(err_tag_mismatch), FW'(1));

        // 5b: early beat_last on beat 1.
        apply_reset();
        send_beat(0, D0, 8'h44, 1'b0);
        send_beat(1, D1, 8'h44, 1'b1);
        beat_vld = 1'b0;
        check("early_last_flag", FW'(err_beat_count), FW'(1));
        send_beat(2, D2, 8'h44, 1'b0);
        beat_vld = 1'b0;
        check("early_last_no_line", FW'(line_vld), FW'(0));
        send_beat(3, D3, 8'h44, 1'b1);
        beat_vld = 1'b0;
        check("early_last_completes", FW'(line_vld), FW'(1));
        check("early_last_data", line_data, ref_line);
        idle(2);

        // 5c: duplicate beat right after reset: position 2 never written stays 0.
        apply_reset();
        send_beat(0, D0, 8'h21, 1'b0);
        send_beat(1, D1, 8'h21, 1'b0);
        send_beat(1, D2, 8'h21, 1'b0);
        send_beat(3, D3, 8'h21, 1'b1);
        beat_vld = 1'b0;
        check("dup_flag", FW'(err_beat_count), FW'(1));
        check("dup_data", line_data, {D3, 64'h0, D2, D0});
        idle(2);

        // 6: reset with a held line and a partial line.
        apply_reset();
        line_rdy = 1'b0;
        for (int i = 0; i < NB; i++) send_beat(i, 64'hDEAD_0000 + 64'(i), 8'h66, i == NB - 1);
        send_beat(0, 64'hBAD0, 8'h67, 1'b0);
        send_beat(1, 64'hBAD1, 8'h67, 1'b0);
        beat_vld = 1'b0;
        check("pre_rst_vld", FW'(line_vld), FW'(1));
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("async_rst_vld", FW'(line_vld), FW'(0));
        check("async_rst_busy", FW'(busy), FW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        line_rdy = 1'b1;
        idle(2);
        check("post_rst_no_vld", FW'(line_vld), FW'(0));
        send_beat(3, D3, 8'h68, 1'b0);
        send_beat(1, D1, 8'h68, 1'b0);
        send_beat(0, D0, 8'h68, 1'b0);
        send_beat(2, D2, 8'h68, 1'b1);
        beat_vld = 1'b0;
        check("post_rst_data", line_data, ref_line);
        check("post_rst_tag", FW'(line_tag), FW'(8'h68));
        idle(2);

        // Randomized lines: random order, data, tag, gaps and back-pressure.
        apply_reset();
        rand_rdy = 1'b1;
        for (int l = 0; l < 24; l++) begin
            for (int i = 0; i < NB; i++) order[i] = i;
            for (int i = NB - 1; i > 0; i--) begin
                int j;
                int t;
                j        = int'($urandom_range(0, i));
                t        = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            rtag = TW'($urandom);
            for (int i = 0; i < NB; i++) rd[i] = {$urandom, $urandom};
            for (int i = 0; i < NB; i++) begin
                send_beat(order[i], rd[i], rtag, i == NB - 1);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rand_rdy = 1'b0;
        line_rdy = 1'b1;
        beat_vld = 1'b0;
        budget   = 0;
        while ((exp_q.size() != 0 || line_vld) && budget < 50) begin
            tick();
            budget++;
        end
        check("rand_drained", FW'(exp_q.size()), FW'(0));
        check("rand_end_vld", FW'(line_vld), FW'(0));
        check("rand_end_busy", FW'(busy), FW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
